// File: rtl/alu_muldiv_seq.sv
// Sequential MUL/DIVU/REMU engine that borrows the EX-stage ALU.
// Latency is fixed per op so the hazard unit can stall deterministically.
module alu_muldiv_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [DATA_WIDTH-1:0]    opa,
    input  logic [DATA_WIDTH-1:0]    opb,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic                     alu_own,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD  = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] ALU_SUB  = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] ALU_SLTU = OPCODE_LENGTH'(4'b1010);

    localparam logic [5:0] LAST = 6'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, MUL_ADD, DIV_CMP, DIV_SUB, FIN
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplr_q, mplr_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [5:0]            cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  ge_q, ge_d;
    logic [1:0]            op_q, op_d;

    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] rem_n;
    logic [DATA_WIDTH-1:0] q_n;

    // For divides, mcand holds the divisor and acc the partial remainder.
    assign sh = {acc_q[DATA_WIDTH-2:0], mplr_q[DATA_WIDTH-1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ge_q     <= 1'b0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            ge_q     <= ge_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplr_d        = mplr_q;
        result_d      = result_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        ge_d          = ge_q;
        op_d          = op_q;
        rem_n         = acc_q;
        q_n           = mplr_q;
        alu_own       = 1'b0;
        alu_srca      = '0;
        alu_srcb      = '0;
        alu_operation = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    unique case (op)
                        OP_MUL: begin
                            acc_d   = '0;
                            mcand_d = opa;
                            mplr_d  = opb;
                            state_d = MUL_ADD;
                        end
                        OP_DIVU, OP_REMU: begin
                            mcand_d = opb;
                            if (opb == '0) begin
                                result_d = (op == OP_DIVU) ? '1 : opa;
                                state_d  = FIN;
                            end else begin
                                acc_d   = '0;
                                mplr_d  = opa;
                                state_d = DIV_CMP;
                            end
                        end
                        default: begin
                            result_d = '0;
                            state_d  = FIN;
                        end
                    endcase
                end
            end
            MUL_ADD: begin
                alu_own       = 1'b1;
                alu_operation = ALU_ADD;
                alu_srca      = acc_q;
                alu_srcb      = mplr_q[0] ? mcand_q : '0;
                acc_d         = alu_result;
                mcand_d       = mcand_q << 1;
                mplr_d        = mplr_q >> 1;
                cnt_d         = cnt_q + 6'd1;
                if (cnt_q == LAST) begin
                    result_d = alu_result;
                    state_d  = FIN;
                end
            end
            DIV_CMP: begin
                // rem[31] is the hidden 33rd bit of the shifted remainder.
                alu_own       = 1'b1;
                alu_operation = ALU_SLTU;
                alu_srca      = sh;
                alu_srcb      = mcand_q;
                ovf_d         = acc_q[DATA_WIDTH-1];
                ge_d          = acc_q[DATA_WIDTH-1] | ~alu_result[0];
                acc_d         = sh;
                mplr_d        = {mplr_q[DATA_WIDTH-2:0], 1'b0};
                state_d       = DIV_SUB;
            end
            DIV_SUB: begin
                alu_own       = 1'b1;
                alu_operation = ALU_SUB;
                alu_srca      = acc_q;
                alu_srcb      = mcand_q;
                rem_n         = ge_q ? alu_result : acc_q;
                q_n           = {mplr_q[DATA_WIDTH-1:1], mplr_q[0] | ge_q};
                acc_d         = rem_n;
                mplr_d        = q_n;
                if (cnt_q == LAST) begin
                    result_d = (op_q == OP_DIVU) ? q_n : rem_n;
                    state_d  = FIN;
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                    state_d = DIV_CMP;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FIN);
    assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a behavioural ALU beside it.
// Directed vectors; a monitor checks result, latency and ALU usage on done.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_own;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [3:0]  alu_operation;
    logic [31:0] alu_result;

    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] SUB  = 4'b0110;
    localparam logic [3:0] SLTU = 4'b1010;

    localparam int K_MUL  = 0;
    localparam int K_DIV  = 1;
    localparam int K_NONE = 2;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        int          own;
        int          kind;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int own_cnt = 0;
    int bad_op = 0;
    logic [31:0] last_res = '0;

    alu_muldiv_seq #(
        .DATA_WIDTH(32),
        .OPCODE_LENGTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op(op),
        .opa(opa),
        .opb(opb),
        .busy(busy),
        .done(done),
        .result(result),
        .alu_own(alu_own),
        .alu_srca(alu_srca),
        .alu_srcb(alu_srcb),
        .alu_operation(alu_operation),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        alu_result = '0;
        case (alu_operation)
            ADD:     alu_result = alu_srca + alu_srcb;
            SUB:     alu_result = alu_srca - alu_srcb;
            SLTU:    alu_result = {31'b0, alu_srca < alu_srcb};
            default: alu_result = '0;
        endcase
    end

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] want;
        if (!rst_n) begin
            own_cnt  = 0;
            bad_op   = 0;
            last_res = '0;
        end else begin
            if (alu_own) begin
                if (sb.size() > 0 && sb[0].kind == K_MUL)
                    want = ADD;
                else
                    want = (own_cnt % 2 == 0) ? SLTU : SUB;
                if (alu_operation != want)
                    bad_op++;
                own_cnt++;
            end else if (alu_srca != 0 || alu_srcb != 0 ||
                         alu_operation != 0) begin
                bad_op++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_done result=%h", result);
                end else begin
                    e = sb.pop_front();
                    checks += 4;
                    if (result !== e.res) begin
                        errors++;
                        $display("FAIL result got=%h exp=%h",
                                 result, e.res);
                    end
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL latency got=%0d exp=%0d",
                                 cyc, e.cyc);
                    end
                    if (own_cnt != e.own) begin
                        errors++;
                        $display("FAIL alu_own_cycles got=%0d exp=%0d",
                                 own_cnt, e.own);
                    end
                    if (bad_op != 0) begin
                        errors++;
                        $display("FAIL alu_drive bad=%0d exp=0", bad_op);
                    end
                    last_res = e.res;
                end
                own_cnt = 0;
                bad_op  = 0;
            end else begin
                checks++;
                if (result !== last_res) begin
                    errors++;
                    $display("FAIL result_hold got=%h exp=%h",
                             result, last_res);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r,
                         input int lat, input int own, input int kind);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk);
        #1;
        sb.push_back('{res: r, cyc: cyc + lat - 1, own: own, kind: kind});
        start = 1'b0;
        opa   = ~a;
        opb   = b ^ 32'h5A5A_5A5A;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) return;
        end
        errors++;
        checks++;
        $display("FAIL timeout pending=%0d exp=0", sb.size());
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        opa   = '0;
        opb   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_own", {31'b0, alu_own}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        issue(2'b00, 32'd7, 32'd6, 32'd42, 33, 32, K_MUL);
        wait_idle();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33, 32, K_MUL);
        wait_idle();
        issue(2'b00, 32'h1_0000, 32'h1_0000, 32'h0, 33, 32, K_MUL);
        wait_idle();
        issue(2'b01, 32'd100, 32'd7, 32'd14, 65, 64, K_DIV);
        wait_idle();
        issue(2'b10, 32'd100, 32'd7, 32'd2, 65, 64, K_DIV);
        wait_idle();
        issue(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1,
              65, 64, K_DIV);
        wait_idle();
        issue(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE,
              65, 64, K_DIV);
        wait_idle();
        issue(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, K_NONE);
        wait_idle();
        issue(2'b10, 32'd5, 32'd0, 32'd5, 1, 0, K_NONE);
        wait_idle();
        issue(2'b11, 32'd123, 32'd45, 32'd0, 1, 0, K_NONE);
        wait_idle();

        // A second start while busy must be dropped.
        issue(2'b00, 32'd7, 32'd6, 32'd42, 33, 32, K_MUL);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        opa   = 32'd1000;
        opb   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("busy_after_drop", {31'b0, busy}, 32'd0);

        // Abort a divide in cycle 10.
        issue(2'b01, 32'd100, 32'd7, 32'd14, 65, 64, K_DIV);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_own", {31'b0, alu_own}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        chk("abort_no_done", {31'b0, done}, 32'd0);

        issue(2'b00, 32'd3, 32'd3, 32'd9, 33, 32, K_MUL);
        wait_idle();
        issue(2'b10, 32'd1000, 32'd3, 32'd1, 65, 64, K_DIV);
        wait_idle();

        chk("sb_empty", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
